load_store_unit: RTL

Multi-cycle data-memory access stage that sits directly upstream of the load-size mux. It accepts one load/store request from the core and drives a variable-latency data-memory bus using a req/ack handshake.
- Stores: generates byte enables and lane-replicated write data.
- Loads: returns the read word right-shifted so the addressed byte/halfword lands in bits [7:0]/[15:0], plus funct3 as the size-mux select.
- Also detects misaligned and illegal accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_lane_align.sv | 37 +++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state type and access-legality helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } lsuState_e;

   // A store may only be byte, half or word; loads add the two unsigned variants.
   function automatic logic isLegalAccess(input logic we, input logic [2:0] funct3);
      logic legal;
      if (we) begin
         legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
      end else begin
         legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                 (funct3 == LBU) || (funct3 == LHU);
      end
      return legal;
   endfunction

   // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
   function automatic logic isMisaligned(input logic [1:0] sizeCode, input logic [1:0] addrLow);
      logic mis;
      mis = 1'b0;
      if (sizeCode == 2'b01) begin
         mis = addrLow[0];
      end else if (sizeCode == 2'b10) begin
         mis = (addrLow != 2'b00);
      end
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, load data shifted to bit 0.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addrLow,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdataRep,
   output logic [31:0] rdataShift
);

   // Enables follow the store size and offset; data is copied into every lane so the enables pick the right one.
   always_comb begin
      be       = 4'b0000;
      wdataRep = wdata;
      if (we) begin
         case (funct3)
            SB:      be = 4'b0001 << addrLow;
            SH:      be = 4'b0011 << addrLow;
            SW:      be = 4'b1111;
            default: be = 4'b0000;
         endcase
      end
      case (funct3[1:0])
         2'b00:   wdataRep = {4{wdata[7:0]}};
         2'b01:   wdataRep = {2{wdata[15:0]}};
         default: wdataRep = wdata;
      endcase
   end

   // Loads move the addressed byte/halfword down to bit 0; extension is left to the size mux downstream.
   assign rdataShift = rdata >> {addrLow, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage with req/ack bus handshake, error detection and bus timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [2:0]        resp_sel,
   output logic              resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsuState_e        state;
   lsuState_e        nextState;
   logic [CNT_W-1:0] timeoutCnt;
   logic             weReg;
   logic [2:0]       funct3Reg;
   logic [1:0]       addrLowReg;
   logic             accept;
   logic             reqOk;
   logic             timedOut;
   logic             alignWe;
   logic [2:0]       alignFunct3;
   logic [1:0]       alignAddrLow;
   logic [3:0]       alignBe;
   logic [31:0]      alignWdata;
   logic [31:0]      alignRdata;

   assign accept   = req_valid && (state == IDLE);
   assign reqOk    = isLegalAccess(req_we, req_funct3) &&
                     !isMisaligned(req_funct3[1:0], req_addr[1:0]);
   assign timedOut = !mem_ack && (timeoutCnt == CNT_LAST);

   // While idle the aligner looks at the incoming request; afterwards it looks at the captured one.
   assign alignWe      = (state == IDLE) ? req_we        : weReg;
   assign alignFunct3  = (state == IDLE) ? req_funct3    : funct3Reg;
   assign alignAddrLow = (state == IDLE) ? req_addr[1:0] : addrLowReg;

   lsu_lane_align u_align (
      .we         (alignWe),
      .funct3     (alignFunct3),
      .addrLow    (alignAddrLow),
      .wdata      (req_wdata),
      .rdata      (mem_rdata),
      .be         (alignBe),
      .wdataRep   (alignWdata),
      .rdataShift (alignRdata)
   );

   // State register; reset abandons any access in flight so mem_req falls immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Bad requests skip the bus; bus accesses end on ack or when the wait budget runs out.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               nextState = reqOk ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            if (mem_ack || timedOut) begin
               nextState = RESP;
            end
         end
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Handshake and bus strobes come straight from the state.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_req    = 1'b0;
      case (state)
         IDLE:    req_ready  = 1'b1;
         ISSUE:   mem_req    = 1'b1;
         RESP:    resp_valid = 1'b1;
         default: req_ready  = 1'b0;
      endcase
   end

   // Capture the request and launch the bus fields so they stay stable for the whole wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         weReg      <= 1'b0;
         funct3Reg  <= 3'b000;
         addrLowReg <= 2'b00;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0;
         mem_be     <= 4'b0000;
      end else if (accept) begin
         weReg      <= req_we;
         funct3Reg  <= req_funct3;
         addrLowReg <= req_addr[1:0];
         if (reqOk) begin
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= alignWdata;
            mem_be    <= alignBe;
         end
      end
   end

   // Count unacknowledged bus cycles; the count restarts with every accepted request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeoutCnt <= '0;
      end else if (accept) begin
         timeoutCnt <= '0;
      end else if ((state == ISSUE) && !mem_ack && !timedOut) begin
         timeoutCnt <= timeoutCnt + CNT_W'(1);
      end
   end

   // Response fields load once on the way into RESP and then hold until the next response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_rdata <= 32'h0;
         resp_sel   <= 3'b000;
         resp_err   <= 1'b0;
      end else if (accept && !reqOk) begin
         resp_rdata <= 32'h0;
         resp_sel   <= req_funct3;
         resp_err   <= 1'b1;
      end else if ((state == ISSUE) && mem_ack) begin
         resp_rdata <= weReg ? 32'h0 : alignRdata;
         resp_sel   <= funct3Reg;
         resp_err   <= 1'b0;
      end else if ((state == ISSUE) && timedOut) begin
         resp_rdata <= 32'h0;
         resp_sel   <= funct3Reg;
         resp_err   <= 1'b1;
      end
   end

endmodule
